path_sched_ctrl: RTL

- Traversal scheduler that sequences the graph datapath for one run of path counting.
- Keeps a work queue of node indices and walks each node's child list from adjacency memory.
- For every edge it issues an accumulate request (paths[src] added to paths[dst]), and enqueues children the accumulator reports as ready (remaining in-degree reached 0).
- Sits inside digital_top between the start/part-select controls, adjacency memory and the path accumulator. Drives the node_idx_reg / next_node_idx / next_node_counter debug outputs.

---
 rtl/path_sched_pkg.sv | 25 ++
 rtl/path_sched_fifo.sv | 56 +++++
 rtl/path_sched_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/path_sched_pkg.sv
// Shared types and defaults for the path-count traversal scheduler.
package path_sched_pkg;

    localparam int NODE_IDX_WIDTH_DEF = 10;
    localparam int COUNTER_WIDTH_DEF  = 4;
    localparam int FIFO_DEPTH_DEF     = 32;

    typedef enum logic [3:0] {
        IDLE,
        SEED,
        POP,
        ADJ_RD,
        ADJ_WAIT,
        EDGE_RD,
        EDGE_WAIT,
        ACC_REQ,
        ACC_RSP,
        DONE
    } state_e;

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/path_sched_fifo.sv
// Work queue of node indices: power-of-two depth, wrapping pointers, head read from storage.
module path_sched_fifo
    import path_sched_pkg::*;
#(
    parameter int WIDTH = NODE_IDX_WIDTH_DEF,
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PTR_W = ptr_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
                count_q  <= count_q + 1'b1;
            end else if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                count_q  <= count_q - 1'b1;
            end
        end
    end

    // NOTE: storage is deliberately not reset; empty_o guards every read of stale data.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/path_sched_ctrl.sv
// Traversal scheduler: pops nodes, walks their child lists and issues accumulate requests.
module path_sched_ctrl
    import path_sched_pkg::*;
#(
    parameter int NODE_IDX_WIDTH = NODE_IDX_WIDTH_DEF,
    parameter int COUNTER_WIDTH  = COUNTER_WIDTH_DEF,
    parameter int FIFO_DEPTH     = FIFO_DEPTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      part_sel,
    input  logic                      start_run,
    input  logic [NODE_IDX_WIDTH-1:0] start_idx_p1,
    input  logic [NODE_IDX_WIDTH-1:0] start_idx_p2,
    output logic                      adj_rd_en,
    output logic [NODE_IDX_WIDTH-1:0] adj_rd_node,
    input  logic [COUNTER_WIDTH-1:0]  adj_rd_cnt,
    output logic                      edge_rd_en,
    output logic [COUNTER_WIDTH-1:0]  edge_rd_slot,
    input  logic [NODE_IDX_WIDTH-1:0] edge_rd_child,
    output logic                      acc_valid,
    input  logic                      acc_ready,
    output logic [NODE_IDX_WIDTH-1:0] acc_src,
    output logic [NODE_IDX_WIDTH-1:0] acc_dst,
    input  logic                      acc_rsp_ready,
    output logic [NODE_IDX_WIDTH-1:0] node_idx_reg,
    output logic [NODE_IDX_WIDTH-1:0] next_node_idx,
    output logic [COUNTER_WIDTH-1:0]  next_node_counter,
    output logic                      busy,
    output logic                      done,
    output logic                      overflow
);
    state_e                    state_q, state_d;
    logic [NODE_IDX_WIDTH-1:0] node_idx_q, node_idx_d;
    logic [NODE_IDX_WIDTH-1:0] next_node_q, next_node_d;
    logic [NODE_IDX_WIDTH-1:0] start_idx_q, start_idx_d;
    logic [COUNTER_WIDTH-1:0]  counter_q, counter_d;
    logic [COUNTER_WIDTH-1:0]  child_cnt_q, child_cnt_d;
    logic                      overflow_q, overflow_d;
    logic                      done_q, done_d;

    logic                      fifo_clr, fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [NODE_IDX_WIDTH-1:0] fifo_push_data, fifo_head;

    path_sched_fifo #(
        .WIDTH (NODE_IDX_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (fifo_clr),
        .push_i      (fifo_push),
        .push_data_i (fifo_push_data),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // NOTE: every signal gets its default before the case so no path can infer a latch.
    always_comb begin
        state_d        = state_q;
        node_idx_d     = node_idx_q;
        next_node_d    = next_node_q;
        start_idx_d    = start_idx_q;
        counter_d      = counter_q;
        child_cnt_d    = child_cnt_q;
        overflow_d     = overflow_q;
        done_d         = 1'b0;
        fifo_clr       = 1'b0;
        fifo_push      = 1'b0;
        fifo_pop       = 1'b0;
        fifo_push_data = next_node_q;

        case (state_q)
            IDLE, DONE: begin
                if (start_run) begin
                    state_d     = SEED;
                    fifo_clr    = 1'b1;
                    overflow_d  = 1'b0;
                    start_idx_d = part_sel ? start_idx_p2 : start_idx_p1;
                end
            end
            SEED: begin
                fifo_push      = 1'b1;
                fifo_push_data = start_idx_q;
                state_d        = POP;
            end
            POP: begin
                if (fifo_empty) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    fifo_pop   = 1'b1;
                    node_idx_d = fifo_head;
                    counter_d  = '0;
                    state_d    = ADJ_RD;
                end
            end
            ADJ_RD:   state_d = ADJ_WAIT;
            ADJ_WAIT: begin
                child_cnt_d = adj_rd_cnt;
                state_d     = (adj_rd_cnt == '0) ? POP : EDGE_RD;
            end
            EDGE_RD:  state_d = EDGE_WAIT;
            EDGE_WAIT: begin
                next_node_d = edge_rd_child;
                state_d     = ACC_REQ;
            end
            ACC_REQ: begin
                if (acc_ready) state_d = ACC_RSP;
            end
            ACC_RSP: begin
                fifo_push = acc_rsp_ready;
                // Count tops out at 2^W-1, so the last increment reaches it without wrapping.
                counter_d = counter_q + 1'b1;
                state_d   = (counter_d == child_cnt_q) ? POP : EDGE_RD;
            end
            default: state_d = IDLE;
        endcase

        if (fifo_push && fifo_full) overflow_d = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            node_idx_q  <= '0;
            next_node_q <= '0;
            start_idx_q <= '0;
            counter_q   <= '0;
            child_cnt_q <= '0;
            overflow_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            node_idx_q  <= node_idx_d;
            next_node_q <= next_node_d;
            start_idx_q <= start_idx_d;
            counter_q   <= counter_d;
            child_cnt_q <= child_cnt_d;
            overflow_q  <= overflow_d;
            done_q      <= done_d;
        end
    end

    // Request strobes decode the state register only; payloads come from registers.
    assign adj_rd_en         = (state_q == ADJ_RD);
    assign edge_rd_en        = (state_q == EDGE_RD);
    assign acc_valid         = (state_q == ACC_REQ);
    assign adj_rd_node       = node_idx_q;
    assign edge_rd_slot      = counter_q;
    assign acc_src           = node_idx_q;
    assign acc_dst           = next_node_q;
    assign node_idx_reg      = node_idx_q;
    assign next_node_idx     = next_node_q;
    assign next_node_counter = counter_q;
    assign busy              = (state_q != IDLE) && (state_q != DONE);
    assign done              = done_q;
    assign overflow          = overflow_q;

endmodule
